// File: rtl/sound_event_player.sv
// Plays one fixed-length sine tone per paddle/brick event on clk50mhz.
// Events come from the clk_ball domain and are resynchronised here.
module sound_event_player #(
    parameter int NOTE1_LIMIT    = 2986,
    parameter int NOTE2_LIMIT    = 2660,
    parameter int DURATION_TICKS = 5000000
) (
    input  logic       clk50mhz,
    input  logic       reset_button,
    input  logic       play_sound1,
    input  logic       play_sound2,
    output logic [3:0] tono,
    output logic       busy,
    output logic [1:0] note_id
);

    localparam int MAXL = (NOTE1_LIMIT > NOTE2_LIMIT) ? NOTE1_LIMIT : NOTE2_LIMIT;
    localparam int SW   = $clog2(2 * MAXL);
    localparam int DW   = $clog2(DURATION_TICKS);

    localparam logic [SW-1:0] TC1      = SW'(2 * NOTE1_LIMIT - 1);
    localparam logic [SW-1:0] TC2      = SW'(2 * NOTE2_LIMIT - 1);
    localparam logic [DW-1:0] DUR_LOAD = DW'(DURATION_TICKS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PLAY = 1'b1;

    logic [1:0]    s1_q, s2_q;
    logic          p1_q, p2_q;
    logic [0:0]    state_q, state_d;
    logic [1:0]    note_q, note_d;
    logic [SW-1:0] step_q, step_d;
    logic [4:0]    addr_q, addr_d;
    logic [DW-1:0] dur_q, dur_d;
    logic [3:0]    tono_q, tono_d;

    logic          ev1, ev2, any_ev;
    logic [1:0]    new_note;
    logic [SW-1:0] tc;

    function automatic logic [3:0] sine(input logic [4:0] a);
        logic [3:0] v;
        case (a)
            5'd0:  v = 4'd8;   5'd1:  v = 4'd9;
            5'd2:  v = 4'd10;  5'd3:  v = 4'd12;
            5'd4:  v = 4'd13;  5'd5:  v = 4'd14;
            5'd6:  v = 4'd14;  5'd7:  v = 4'd15;
            5'd8:  v = 4'd15;  5'd9:  v = 4'd15;
            5'd10: v = 4'd14;  5'd11: v = 4'd14;
            5'd12: v = 4'd13;  5'd13: v = 4'd12;
            5'd14: v = 4'd10;  5'd15: v = 4'd9;
            5'd16: v = 4'd8;   5'd17: v = 4'd6;
            5'd18: v = 4'd5;   5'd19: v = 4'd3;
            5'd20: v = 4'd2;   5'd21: v = 4'd1;
            5'd22: v = 4'd1;   5'd23: v = 4'd0;
            5'd24: v = 4'd0;   5'd25: v = 4'd0;
            5'd26: v = 4'd1;   5'd27: v = 4'd1;
            5'd28: v = 4'd2;   5'd29: v = 4'd3;
            5'd30: v = 4'd5;   5'd31: v = 4'd6;
            default: v = 4'd8;
        endcase
        return v;
    endfunction

    // Rising-edge detect after the synchroniser; note 2 wins a tie.
    assign ev1      = s1_q[1] & ~p1_q;
    assign ev2      = s2_q[1] & ~p2_q;
    assign any_ev   = ev1 | ev2;
    assign new_note = ev2 ? 2'd2 : 2'd1;
    assign tc       = (note_q == 2'd2) ? TC2 : TC1;

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        step_d  = step_q;
        addr_d  = addr_q;
        dur_d   = dur_q;
        case (state_q)
            S_IDLE: begin
                if (any_ev) begin
                    state_d = S_PLAY;
                    note_d  = new_note;
                    dur_d   = DUR_LOAD;
                    step_d  = '0;
                    addr_d  = '0;
                end
            end
            default: begin
                if (any_ev) begin
                    // Retrigger keeps the address so the waveform stays continuous.
                    note_d = new_note;
                    dur_d  = DUR_LOAD;
                    step_d = '0;
                end else if (dur_q == '0) begin
                    state_d = S_IDLE;
                    note_d  = 2'd0;
                    step_d  = '0;
                    addr_d  = '0;
                end else begin
                    dur_d = dur_q - DW'(1);
                    if (step_q == tc) begin
                        step_d = '0;
                        addr_d = addr_q + 5'd1;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
        endcase
        tono_d = (state_q == S_PLAY) ? sine(addr_q) : 4'd8;
    end

    always_ff @(posedge clk50mhz) begin
        if (reset_button) begin
            s1_q    <= '0;
            s2_q    <= '0;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
            state_q <= S_IDLE;
            note_q  <= 2'd0;
            step_q  <= '0;
            addr_q  <= '0;
            dur_q   <= '0;
            tono_q  <= 4'd8;
        end else begin
            s1_q    <= {s1_q[0], play_sound1};
            s2_q    <= {s2_q[0], play_sound2};
            p1_q    <= s1_q[1];
            p2_q    <= s2_q[1];
            state_q <= state_d;
            note_q  <= note_d;
            step_q  <= step_d;
            addr_q  <= addr_d;
            dur_q   <= dur_d;
            tono_q  <= tono_d;
        end
    end

    assign tono    = tono_q;
    assign busy    = (state_q == S_PLAY);
    assign note_id = note_q;

endmodule

// File: tb/tb_sound_event_player.sv
// Directed bench for sound_event_player with short notes and tones.
module tb_sound_event_player;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps1, ps2;
    logic [3:0] tono;
    logic       busy;
    logic [1:0] note_id;

    int n_chk  = 0;
    int n_fail = 0;
    int rises  = 0;
    int r0;
    logic busy_m = 1'b0;

    int tbl [32] = '{8, 9, 10, 12, 13, 14, 14, 15, 15, 15, 14, 14, 13, 12, 10, 9,
                     8, 6, 5, 3, 2, 1, 1, 0, 0, 0, 1, 1, 2, 3, 5, 6};

    sound_event_player #(
        .NOTE1_LIMIT(3),
        .NOTE2_LIMIT(2),
        .DURATION_TICKS(40)
    ) dut (
        .clk50mhz(clk),
        .reset_button(rst),
        .play_sound1(ps1),
        .play_sound2(ps2),
        .tono(tono),
        .busy(busy),
        .note_id(note_id)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy && !busy_m) rises++;
        busy_m = busy;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise inputs, then expect busy two edges after first sampling.
    task automatic arm(input logic s1, input logic s2, input int nid);
        if (s1) ps1 = 1'b1;
        if (s2) ps2 = 1'b1;
        tick();
        tick();
        check("pre_busy", busy, 0);
        tick();
        check("rise_busy", busy, 1);
        check("rise_note", note_id, nid);
        check("rise_tono", tono, 8);
    endtask

    // Called just after the rising edge of busy.
    task automatic chk_tone(input int len, input int p, input int nid);
        for (int n = 1; n <= len + 2; n++) begin
            tick();
            check($sformatf("busy@%0d", n), busy, (n < len) ? 1 : 0);
            check($sformatf("note@%0d", n), note_id, (n < len) ? nid : 0);
            check($sformatf("tono@%0d", n), tono,
                  (n <= len) ? tbl[((n - 1) / p) % 32] : 8);
        end
    endtask

    initial begin
        // 1: reset with random inputs
        rst = 1'b1;
        ps1 = 1'($urandom);
        ps2 = 1'($urandom);
        tick();
        tick();
        check("rst_tono", tono, 8);
        check("rst_busy", busy, 0);
        check("rst_note", note_id, 0);
        rst = 1'b0;
        ps1 = 1'b0;
        ps2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_busy", busy, 0);
        end

        // 2: single note 1, input held high
        arm(1'b1, 1'b0, 1);
        chk_tone(40, 6, 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_busy", busy, 0);
        end
        ps1 = 1'b0;
        tick();
        tick();
        tick();

        // 3: simultaneous events, note 2 wins
        arm(1'b1, 1'b1, 2);
        ps1 = 1'b0;
        ps2 = 1'b0;
        chk_tone(40, 4, 2);
        tick();
        tick();

        // 4a: retrigger 20 cycles into a note-1 tone
        arm(1'b1, 1'b0, 1);
        ps1 = 1'b0;
        for (int n = 1; n <= 62; n++) begin
            tick();
            check("rt_busy", busy, (n < 60) ? 1 : 0);
            check("rt_note", note_id, (n < 20) ? 1 : (n < 60) ? 2 : 0);
            check($sformatf("rt_tono@%0d", n), tono,
                  (n <= 20) ? tbl[(n - 1) / 6] :
                  (n <= 60) ? tbl[3 + (n - 21) / 4] : 8);
            if (n == 17) ps2 = 1'b1;
            if (n == 20) ps2 = 1'b0;
        end
        tick();
        tick();

        // 4b: event lands exactly on the expiry cycle
        arm(1'b1, 1'b0, 1);
        ps1 = 1'b0;
        for (int n = 1; n <= 82; n++) begin
            tick();
            check("exp_busy", busy, (n < 80) ? 1 : 0);
            check("exp_note", note_id, (n < 40) ? 1 : (n < 80) ? 2 : 0);
            check($sformatf("exp_tono@%0d", n), tono,
                  (n <= 40) ? tbl[(n - 1) / 6] :
                  (n <= 80) ? tbl[6 + (n - 41) / 4] : 8);
            if (n == 37) ps2 = 1'b1;
            if (n == 40) ps2 = 1'b0;
        end
        tick();
        tick();

        // 5: reset mid-tone with input still high
        arm(1'b1, 1'b0, 1);
        for (int n = 1; n <= 14; n++) tick();
        rst = 1'b1;
        tick();
        check("mr_busy", busy, 0);
        check("mr_tono", tono, 8);
        check("mr_note", note_id, 0);
        rst = 1'b0;
        tick();
        check("mr_busy1", busy, 0);
        tick();
        check("mr_busy2", busy, 0);
        tick();
        check("mr_rise", busy, 1);
        check("mr_rnote", note_id, 1);
        chk_tone(40, 6, 1);
        ps1 = 1'b0;
        tick();
        tick();

        // 6: ten pulses, one every 100 cycles
        r0 = rises;
        for (int i = 0; i < 10; i++) begin
            arm(1'b1, 1'b0, 1);
            ps1 = 1'b0;
            chk_tone(40, 6, 1);
            for (int j = 0; j < 55; j++) tick();
        end
        check("long_tones", rises - r0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
